bp_stall_hist_counters: RTL and testbench
=========================================

Name: bp_stall_hist_counters

Overview:
- Synthesizable per-core stall-attribution counter bank.
- Sits directly downstream of the commit-stage stall profiler. Each cycle it consumes the profiler's output: the commit valid flag, the stall-valid flag and the priority-encoded stall-reason code.
- Accumulates one counter per stall reason, plus counters for unattributed cycles, committed instructions and total counted cycles.
- Counters are exposed through an atomic snapshot bank and a valid/yumi read port for the debug/CSR path.

Parameters:
- num_reasons_p, 21, number of stall-reason bins; codes 0..num_reasons_p-1 are valid.
- reason_width_p, 5, width of the stall-reason code.
- cnt_width_p, 32, width of each counter.
- addr_width_p, 5, read address width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- freeze_i  in  1  core frozen; no counting while high
- commit_v_i  in  1  instruction committed this cycle
- stall_v_i  in  1  stall reason valid this cycle
- stall_reason_i  in  reason_width_p  encoded stall reason
- clear_i  in  1  zero all live counters and overflow bits
- snapshot_i  in  1  copy live counters into the shadow bank
- rd_v_i  in  1  read request
- rd_addr_i  in  addr_width_p  read address
- rd_ready_o  out  1  read request accepted when rd_v_i & rd_ready_o
- rd_data_v_o  out  1  read data valid
- rd_data_o  out  cnt_width_p  read data
- rd_yumi_i  in  1  consumer takes rd_data_o

Behaviour:
- Reset (reset_n_i low, asynchronous): all live counters, shadow counters, overflow bits and input-stage registers go to 0.
  - Outputs during/after reset: rd_ready_o=1, rd_data_v_o=0, rd_data_o=0, FSM in READY.
  - If reset is asserted mid-read, the pending response is dropped.
- Input stage: freeze_i, commit_v_i, stall_v_i and stall_reason_i are registered once.
  - An event sampled at edge N updates the live counters at edge N+1.
- Update rule, evaluated on the registered inputs, exactly one bin per unfrozen cycle:
  - frozen: no update; cycle counter also holds.
  - else if commit_v: instr counter +1.
  - else if stall_v and reason < num_reasons_p: hist[reason] +1.
  - else (no stall_v, or reason out of range): unknown counter +1.
  - In every unfrozen case the cycle counter also increments. Invariant: cycle = instr + unknown + sum(hist).
- Overflow: an increment at all-ones sets that counter's sticky overflow bit.
  - Counter value at overflow is governed by the Optional Feature.
- clear_i: at the edge it is sampled, all live counters and overflow bits become 0.
  - Any event in the input stage at that edge is discarded; clear wins over increment.
  - The shadow bank is untouched.
- snapshot_i: at the edge it is sampled, the shadow bank takes the live register values as they stood before that edge's update.
  - snapshot_i and clear_i in the same cycle give an atomic read-and-clear: the shadow holds pre-clear values.
  - snapshot_i is accepted in any FSM state; a response already held on rd_data_o is not altered.
- Read FSM:
  - READY: rd_ready_o=1. On rd_v_i, register shadow[rd_addr_i] into rd_data_o and go to RESP; data is valid the next cycle (latency 1).
  - RESP: rd_ready_o=0, rd_data_v_o=1, rd_data_o held stable. On rd_yumi_i go to READY.
  - RESP->READY takes one cycle; back-to-back requests therefore issue every 2 cycles minimum.
  - rd_yumi_i while not in RESP is ignored.
- Read address map (shadow bank):
  - 0..num_reasons_p-1: hist bins.
  - num_reasons_p: unknown counter.
  - +1: instr counter.
  - +2: cycle counter.
  - +3: overflow mask. bit i = hist[i]; bits num_reasons_p..+2 = unknown/instr/cycle; zero-extended or truncated to cnt_width_p.
  - Any other address returns 0.

Optional Feature:
- Macro: BP_STALL_HIST_SATURATE_EN.
- Defined: counters saturate at all-ones and stay there until clear_i.
- Undefined: counters wrap modulo 2^cnt_width_p.
- In both cases the sticky overflow bit is set on the first increment at all-ones.

Test Plan:
- Reset, then 10 unfrozen cycles with commit_v=1, then snapshot; read addr 22 (instr) -> 10; read addr 23 (cycle) -> 10; read addr 21 (unknown) -> 0.
- 5 cycles stall_v=1 reason=4, then 3 cycles stall_v=1 reason=25, then snapshot; read addr 4 -> 5; read addr 21 -> 3; cycle -> 8.
- freeze_i=1 for 7 cycles with commit_v=1 -> all counters 0 after snapshot; drop freeze and commit 2 cycles -> instr=2.
- Accumulate instr=6, then snapshot and clear in the same cycle; read addr 22 -> 6; next snapshot with no events -> 0.
- cnt_width_p=4, 17 cycles reason=0:
  - with BP_STALL_HIST_SATURATE_EN: read 0 -> 15, mask bit0=1;
  - without: read 0 -> 1, mask bit0=1.
- Read protocol: issue rd_v with addr 23 and hold rd_yumi_i=0 for 3 cycles -> rd_data_v_o=1 and rd_ready_o=0, data stable even across a snapshot. Then yumi -> READY next cycle. Read addr 30 -> 0. Assert reset_n_i low during RESP -> rd_data_v_o=0 immediately.

Source files
------------

// File: rtl/bp_stall_hist_counters.sv
// Per-core stall-attribution counter bank with an atomic snapshot shadow and a valid/yumi read port.
// Optional feature: define BP_STALL_HIST_SATURATE_EN for saturating counters (default build wraps).
module bp_stall_hist_counters #(
  parameter int num_reasons_p  = 21,
  parameter int reason_width_p = 5,
  parameter int cnt_width_p    = 32,
  parameter int addr_width_p   = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      freeze_i,
  input  logic                      commit_v_i,
  input  logic                      stall_v_i,
  input  logic [reason_width_p-1:0] stall_reason_i,
  input  logic                      clear_i,
  input  logic                      snapshot_i,
  input  logic                      rd_v_i,
  input  logic [addr_width_p-1:0]   rd_addr_i,
  output logic                      rd_ready_o,
  output logic                      rd_data_v_o,
  output logic [cnt_width_p-1:0]    rd_data_o,
  input  logic                      rd_yumi_i
);

  // Counter index layout mirrors the read address map: hist bins, unknown, instr, cycle.
  localparam int num_cnt_lp   = num_reasons_p + 3;
  localparam int unk_idx_lp   = num_reasons_p;
  localparam int instr_idx_lp = num_reasons_p + 1;
  localparam int cycle_idx_lp = num_reasons_p + 2;
  localparam int mask_bits_lp = (num_cnt_lp < cnt_width_p) ? num_cnt_lp : cnt_width_p;

  localparam logic [cnt_width_p-1:0] all_ones_lp = '1;
  localparam logic [cnt_width_p-1:0] one_lp      = cnt_width_p'(1);

  localparam logic [0:0] ready_s = 1'b0;
  localparam logic [0:0] resp_s  = 1'b1;

  logic                      freeze_q;
  logic                      commit_q;
  logic                      stall_q;
  logic [reason_width_p-1:0] reason_q;

  logic [cnt_width_p-1:0] live_q   [num_cnt_lp];
  logic [cnt_width_p-1:0] shadow_q [num_cnt_lp];
  logic [num_cnt_lp-1:0]  ovf_q;
  logic [num_cnt_lp-1:0]  shadow_ovf_q;

  logic [num_cnt_lp-1:0]  inc;
  logic [cnt_width_p-1:0] mask;
  logic [cnt_width_p-1:0] rd_sel;
  logic [0:0]             state_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_q <= 1'b0;
      commit_q <= 1'b0;
      stall_q  <= 1'b0;
      reason_q <= '0;
    end else begin
      freeze_q <= freeze_i;
      commit_q <= commit_v_i;
      stall_q  <= stall_v_i;
      reason_q <= stall_reason_i;
    end
  end

  // One-hot selection of the bin charged this cycle; the cycle counter rides along.
  always_comb begin
    // NOTE: default every bit first so the combinational block can never infer a latch.
    inc = '0;
    if (!freeze_q) begin
      inc[cycle_idx_lp] = 1'b1;
      if (commit_q) begin
        inc[instr_idx_lp] = 1'b1;
      end else begin
        for (int i = 0; i < num_reasons_p; i++) begin
          if (stall_q && (reason_q == reason_width_p'(i))) inc[i] = 1'b1;
        end
        if (inc[num_reasons_p-1:0] == '0) inc[unk_idx_lp] = 1'b1;
      end
    end
  end

  // NOTE: the counter banks are flop arrays, not RAM, so they take the async reset like any register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_cnt_lp; i++) live_q[i] <= '0;
      ovf_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < num_cnt_lp; i++) live_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) begin
        if (inc[i]) begin
          if (live_q[i] == all_ones_lp) ovf_q[i] <= 1'b1;
`ifdef BP_STALL_HIST_SATURATE_EN
          if (live_q[i] != all_ones_lp) live_q[i] <= live_q[i] + one_lp;
`else
          live_q[i] <= live_q[i] + one_lp;
`endif
        end
      end
    end
  end

  // Shadow captures pre-update values, which makes snapshot+clear an atomic read-and-clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_cnt_lp; i++) shadow_q[i] <= '0;
      shadow_ovf_q <= '0;
    end else if (snapshot_i) begin
      shadow_q     <= live_q;
      shadow_ovf_q <= ovf_q;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < mask_bits_lp; i++) mask[i] = shadow_ovf_q[i];
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      if (int'(rd_addr_i) == i) rd_sel = shadow_q[i];
    end
    if (int'(rd_addr_i) == num_cnt_lp) rd_sel = mask;
  end

  // Read port: data registered on acceptance and held until the consumer yumis it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ready_s;
      rd_data_o <= '0;
    end else begin
      case (state_q)
        ready_s: begin
          if (rd_v_i) begin
            rd_data_o <= rd_sel;
            state_q   <= resp_s;
          end
        end
        default: begin
          if (rd_yumi_i) state_q <= ready_s;
        end
      endcase
    end
  end

  assign rd_ready_o  = (state_q == ready_s);
  assign rd_data_v_o = (state_q == resp_s);

endmodule

// File: tb/tb_bp_stall_hist_counters.sv
// Bench for bp_stall_hist_counters: a 32-bit and a 4-bit instance share stimulus and are checked
// against an unbounded-count model that derives wrapped/saturated views and overflow from true totals.
module tb_bp_stall_hist_counters;

  localparam int NR = 21;
  localparam int NC = NR + 3;

  logic        clk;
  logic        reset_n;
  logic        freeze, commit_v, stall_v, clear, snapshot, rd_v, rd_yumi;
  logic [4:0]  stall_reason, rd_addr;
  logic        rdy_w, dv_w, rdy_n, dv_n;
  logic [31:0] data_w;
  logic [3:0]  data_n;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: true event totals since the last clear; output views derived per counter width.
  longint      live [NC];
  longint      shadow [NC];
  bit          p_frz, p_commit, p_stall;
  int          p_reason;
  bit          m_resp;
  logic [31:0] m_dw, m_dn;

  bp_stall_hist_counters dut_w (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(commit_v),
    .stall_v_i(stall_v), .stall_reason_i(stall_reason), .clear_i(clear), .snapshot_i(snapshot),
    .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(rdy_w), .rd_data_v_o(dv_w),
    .rd_data_o(data_w), .rd_yumi_i(rd_yumi)
  );

  bp_stall_hist_counters #(.cnt_width_p(4)) dut_n (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(commit_v),
    .stall_v_i(stall_v), .stall_reason_i(stall_reason), .clear_i(clear), .snapshot_i(snapshot),
    .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_ready_o(rdy_n), .rd_data_v_o(dv_n),
    .rd_data_o(data_n), .rd_yumi_i(rd_yumi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] view(input longint c, input int w);
    logic [63:0] maxv;
    logic [63:0] r;
    maxv = (64'd1 << w) - 64'd1;
`ifdef BP_STALL_HIST_SATURATE_EN
    r = (c > longint'(maxv)) ? maxv : 64'(c);
`else
    r = 64'(c) & maxv;
`endif
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_read(input int addr, input int w);
    logic [63:0] maxv;
    logic [63:0] m;
    maxv = (64'd1 << w) - 64'd1;
    if (addr < NC) return view(shadow[addr], w);
    if (addr == NC) begin
      m = '0;
      for (int i = 0; i < NC; i++) if (shadow[i] > longint'(maxv)) m[i] = 1'b1;
      m = m & maxv;
      return m[31:0];
    end
    return 32'd0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) begin
        live[i]   = 0;
        shadow[i] = 0;
      end
      p_frz = 1'b0; p_commit = 1'b0; p_stall = 1'b0; p_reason = 0;
      m_resp = 1'b0; m_dw = '0; m_dn = '0;
    end else begin
      if (!m_resp) begin
        if (rd_v) begin
          m_resp = 1'b1;
          m_dw   = model_read(int'(rd_addr), 32);
          m_dn   = model_read(int'(rd_addr), 4);
        end
      end else if (rd_yumi) begin
        m_resp = 1'b0;
      end
      if (snapshot) shadow = live;
      if (clear) begin
        for (int i = 0; i < NC; i++) live[i] = 0;
      end else if (!p_frz) begin
        live[NR+2]++;
        if (p_commit)                     live[NR+1]++;
        else if (p_stall && p_reason < NR) live[p_reason]++;
        else                              live[NR]++;
      end
      p_frz = freeze; p_commit = commit_v; p_stall = stall_v; p_reason = int'(stall_reason);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_w", {31'd0, rdy_w}, {31'd0, !m_resp});
      check("valid_w", {31'd0, dv_w},  {31'd0, m_resp});
      check("ready_n", {31'd0, rdy_n}, {31'd0, !m_resp});
      check("valid_n", {31'd0, dv_n},  {31'd0, m_resp});
      if (m_resp) begin
        check("data_w", data_w, m_dw);
        check("data_n", {28'd0, data_n}, m_dn);
      end
    end
  end

  task automatic step(input bit f, c, s, input logic [4:0] r, input bit clr, snap);
    @(negedge clk); #1;
    freeze = f; commit_v = c; stall_v = s; stall_reason = r; clear = clr; snapshot = snap;
  endtask

  task automatic idle();
    step(1, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic clear_all();
    step(1, 0, 0, 5'd0, 1, 0);
    idle();
  endtask

  task automatic snap_idle();
    idle();
    step(1, 0, 0, 5'd0, 0, 1);
    idle();
  endtask

  task automatic rd(input int addr, input logic [31:0] ew, input logic [31:0] en, input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    rd_v = 1'b1; rd_addr = 5'(addr);
    @(negedge clk); #1;
    rd_v = 1'b0;
    while (!dv_w && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_w"}, data_w, ew);
    check({name, "_n"}, {28'd0, data_n}, en);
    rd_yumi = 1'b1;
    @(negedge clk); #1;
    rd_yumi = 1'b0;
  endtask

  initial begin
    logic [31:0] sat_exp;
`ifdef BP_STALL_HIST_SATURATE_EN
    sat_exp = 32'd15;
`else
    sat_exp = 32'd1;
`endif
    reset_n = 1'b0;
    freeze = 1'b1; commit_v = 1'b0; stall_v = 1'b0; stall_reason = '0;
    clear = 1'b0; snapshot = 1'b0; rd_v = 1'b0; rd_addr = '0; rd_yumi = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, rdy_w}, 32'd1);
    check("rst_valid", {31'd0, dv_w}, 32'd0);
    check("rst_data", data_w, 32'd0);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    clear_all();

    // Commits only.
    repeat (10) step(0, 1, 0, 5'd0, 0, 0);
    snap_idle();
    rd(22, 32'd10, 32'd10, "instr10");
    rd(23, 32'd10, 32'd10, "cycle10");
    rd(21, 32'd0, 32'd0, "unknown0");

    // In-range and out-of-range stall reasons.
    clear_all();
    repeat (5) step(0, 0, 1, 5'd4, 0, 0);
    repeat (3) step(0, 0, 1, 5'd25, 0, 0);
    snap_idle();
    rd(4, 32'd5, 32'd5, "hist4");
    rd(21, 32'd3, 32'd3, "unknown3");
    rd(23, 32'd8, 32'd8, "cycle8");

    // Freeze suppresses everything, including the cycle counter.
    clear_all();
    repeat (7) step(1, 1, 0, 5'd0, 0, 0);
    snap_idle();
    rd(22, 32'd0, 32'd0, "frz_instr");
    rd(23, 32'd0, 32'd0, "frz_cycle");
    repeat (2) step(0, 1, 0, 5'd0, 0, 0);
    snap_idle();
    rd(22, 32'd2, 32'd2, "instr2");

    // Atomic snapshot-and-clear.
    clear_all();
    repeat (6) step(0, 1, 0, 5'd0, 0, 0);
    idle();
    step(1, 0, 0, 5'd0, 1, 1);
    idle();
    rd(22, 32'd6, 32'd6, "snapclr6");
    snap_idle();
    rd(22, 32'd0, 32'd0, "after_clr");

    // Overflow on the narrow instance.
    clear_all();
    repeat (17) step(0, 0, 1, 5'd0, 0, 0);
    snap_idle();
    rd(0, 32'd17, sat_exp, "ovf_hist0");
    rd(23, 32'd17, sat_exp, "ovf_cycle");
    rd(24, 32'd0, 32'd1, "ovf_mask");

    // Read protocol: hold, stability across snapshot, yumi, unmapped address, reset in RESP.
    clear_all();
    repeat (3) step(0, 1, 0, 5'd0, 0, 0);
    snap_idle();
    @(negedge clk); #1;
    rd_v = 1'b1; rd_addr = 5'd23;
    @(negedge clk); #1;
    rd_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 5'd0, 0, (k == 2));
      check("hold_valid", {31'd0, dv_w}, 32'd1);
      check("hold_ready", {31'd0, rdy_w}, 32'd0);
      check("hold_data", data_w, 32'd3);
    end
    idle();
    check("hold_snap_data", data_w, 32'd3);
    rd_yumi = 1'b1;
    @(negedge clk); #1;
    rd_yumi = 1'b0;
    check("yumi_ready", {31'd0, rdy_w}, 32'd1);
    check("yumi_valid", {31'd0, dv_w}, 32'd0);
    rd(30, 32'd0, 32'd0, "addr30");
    @(negedge clk); #1;
    rd_v = 1'b1; rd_addr = 5'd23;
    @(negedge clk); #1;
    rd_v = 1'b0;
    check("pre_rst_valid", {31'd0, dv_w}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, dv_w}, 32'd0);
    check("midrst_ready", {31'd0, rdy_w}, 32'd1);
    check("midrst_data", data_w, 32'd0);
    @(negedge clk); #2;
    reset_n = 1'b1;

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      freeze       = ($urandom_range(0, 9) == 0);
      commit_v     = ($urandom_range(0, 2) == 0);
      stall_v      = ($urandom_range(0, 3) != 0);
      stall_reason = 5'($urandom_range(0, 31));
      clear        = ($urandom_range(0, 99) < 2);
      snapshot     = ($urandom_range(0, 19) == 0);
      rd_v         = ($urandom_range(0, 1) == 1);
      rd_addr      = 5'($urandom_range(0, 31));
      rd_yumi      = ($urandom_range(0, 1) == 1);
    end
    idle();
    rd_v = 1'b0; rd_yumi = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
